// File: rtl/phased_clock_bank.sv
// Multi-channel phased square-wave generator: one shared period counter, per-channel
// phase and enable, with double-buffered settings applied together at a period boundary.
module phased_clock_bank #(
  parameter int CHANNELS   = 8,
  parameter int CNT_WIDTH  = 11,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-2:0]  divide,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CNT_WIDTH-1:0]  wr_phase,
  input  logic                  wr_enable,
  input  logic                  commit,
  output logic [CHANNELS-1:0]   out,
  output logic                  sync,
  output logic                  pending,
  output logic                  phase_err
);

  // One extra bit so P (up to 2^CNT_WIDTH) and cnt+phase never overflow.
  localparam int EW = CNT_WIDTH + 1;
  typedef logic [EW-1:0] ext_t;
  localparam ext_t ONE_X = ext_t'(1);
  localparam logic [ADDR_WIDTH:0] CH_LIM = CHANNELS[ADDR_WIDTH:0];

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-2:0] active_div_q, active_div_d;
  logic [CNT_WIDTH-1:0] active_phase_q [CHANNELS];
  logic [CNT_WIDTH-1:0] active_phase_d [CHANNELS];
  logic [CHANNELS-1:0]  active_en_q, active_en_d;
  logic [CNT_WIDTH-1:0] shadow_phase_q [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow_phase_d [CHANNELS];
  logic [CHANNELS-1:0]  shadow_en_q, shadow_en_d;
  logic [CHANNELS-1:0]  out_q, out_d;
  logic                 sync_q, sync_d;
  logic                 pending_q, pending_d;
  logic                 phase_err_q, phase_err_d;

  ext_t                 half_s, period_s, new_period_s;
  ext_t                 sum_s [CHANNELS];
  logic [CHANNELS-1:0]  clamp_s;
  logic                 wrap_s, apply_s, wr_hit_s;

  // Period geometry, wrap detection and the apply decision.
  always_comb begin
    half_s       = {2'b00, active_div_q} + ONE_X;
    period_s     = half_s << 1;
    new_period_s = ({2'b00, divide} + ONE_X) << 1;
    wrap_s       = ({1'b0, cnt_q} == (period_s - ONE_X));
    apply_s      = wrap_s & (pending_q | commit);
    wr_hit_s     = wr_en & ({1'b0, wr_addr} < CH_LIM);
  end

  // Counter advance and per-channel output generation from the current count.
  always_comb begin
    cnt_d  = wrap_s ? '0 : (cnt_q + CNT_WIDTH'(1));
    sync_d = wrap_s;
    out_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_s[i] = {1'b0, cnt_q} + {1'b0, active_phase_q[i]};
      if (sum_s[i] >= period_s) begin
        sum_s[i] = sum_s[i] - period_s;
      end else begin
        sum_s[i] = sum_s[i];
      end
      out_d[i] = active_en_q[i] & (sum_s[i] < half_s);
    end
  end

  // Host writes land only in the shadow registers.
  always_comb begin
    shadow_phase_d = shadow_phase_q;
    shadow_en_d    = shadow_en_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_hit_s && (wr_addr == ADDR_WIDTH'(i))) begin
        shadow_phase_d[i] = wr_phase;
        shadow_en_d[i]    = wr_enable;
      end else begin
        shadow_phase_d[i] = shadow_phase_q[i];
        shadow_en_d[i]    = shadow_en_q[i];
      end
    end
  end

  // Commit tracking and the boundary apply with range clamping against the new period.
  always_comb begin
    active_div_d   = active_div_q;
    active_phase_d = active_phase_q;
    active_en_d    = active_en_q;
    pending_d      = pending_q;
    phase_err_d    = phase_err_q;
    for (int i = 0; i < CHANNELS; i++) begin
      clamp_s[i] = ({1'b0, shadow_phase_q[i]} >= new_period_s);
    end
    if (apply_s) begin
      active_div_d = divide;
      active_en_d  = shadow_en_q;
      for (int i = 0; i < CHANNELS; i++) begin
        active_phase_d[i] = clamp_s[i] ? '0 : shadow_phase_q[i];
      end
      pending_d   = 1'b0;
      phase_err_d = |clamp_s;
    end else if (commit) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      active_div_q <= divide;
      active_en_q  <= '0;
      shadow_en_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active_phase_q[i] <= '0;
        shadow_phase_q[i] <= '0;
      end
      out_q       <= '0;
      sync_q      <= 1'b0;
      pending_q   <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      active_div_q   <= active_div_d;
      active_phase_q <= active_phase_d;
      active_en_q    <= active_en_d;
      shadow_phase_q <= shadow_phase_d;
      shadow_en_q    <= shadow_en_d;
      out_q          <= out_d;
      sync_q         <= sync_d;
      pending_q      <= pending_d;
      phase_err_q    <= phase_err_d;
    end
  end

  assign out       = out_q;
  assign sync      = sync_q;
  assign pending   = pending_q;
  assign phase_err = phase_err_q;

endmodule
